// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response, redirect and decode handshake bundle.
// master = fetch stage, slave = surrounding memory/execute/decode environment.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled fetch stage with credit-limited requests, DEPTH-entry FIFO and flush.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects halt fetch and queue a fault entry.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [XLEN-1:0] r_mem_pc   [DEPTH];

    logic            w_req_valid;
    logic            w_accept;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic            w_deq;
    logic            w_enq;
    logic            w_halted;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_enq_data;
    logic [XLEN-1:0] w_enq_pc;
    logic [CW:0]     w_inflight;
    logic [CW-1:0]   w_out_d;
    logic [CW-1:0]   w_flush_cnt;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] NOP = 'h13;

    logic            r_halted;
    logic            r_fault_sent;
    logic [XLEN-1:0] r_fault_pc;
    logic            r_mem_fault [DEPTH];
    logic            w_misaligned;
    logic            w_fault_enq;

    assign w_misaligned  = bus.redirect_pc[1:0] != 2'b00;
    assign w_redirect_pc = bus.redirect_pc;
    // Fault entry waits until every stale response has been discarded and the queue is empty.
    assign w_fault_enq   = r_halted && !r_fault_sent && (r_discard == '0) && (r_count == '0) &&
                           !bus.redirect_valid;
    assign w_halted      = r_halted;
    assign w_enq         = w_rsp_keep || w_fault_enq;
    assign w_enq_pc      = w_fault_enq ? r_fault_pc : r_rsp_pc;
    assign w_enq_data    = w_fault_enq ? NOP : bus.imem_rsp_data;
    assign bus.inst_fault = r_mem_fault[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_halted     <= 1'b0;
            r_fault_sent <= 1'b0;
            r_fault_pc   <= '0;
        end else if (bus.redirect_valid) begin
            r_halted     <= w_misaligned;
            r_fault_sent <= 1'b0;
            if (w_misaligned) r_fault_pc <= bus.redirect_pc;
        end else if (w_fault_enq) begin
            r_fault_sent <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem_fault[i] <= 1'b0;
        end else if (w_enq && !bus.redirect_valid) begin
            r_mem_fault[r_wr_ptr] <= w_fault_enq;
        end
    end
`else
    assign w_redirect_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign w_halted       = 1'b0;
    assign w_enq          = w_rsp_keep;
    assign w_enq_pc       = r_rsp_pc;
    assign w_enq_data     = bus.imem_rsp_data;
    assign bus.inst_fault = 1'b0;
`endif

    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid = reset && !bus.redirect_valid && !w_halted &&
                         (w_inflight < (CW + 1)'(DEPTH));
    assign w_accept    = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop  = bus.imem_rsp_valid && (r_discard != '0);
    assign w_rsp_keep  = bus.imem_rsp_valid && (r_discard == '0);
    assign w_deq       = (r_count != '0) && bus.inst_ready;
    // Everything still in flight after this edge belongs to the old path.
    assign w_flush_cnt = bus.imem_rsp_valid ? r_outstanding - 1'b1 : r_outstanding;

    always_comb begin
        w_out_d = r_outstanding;
        if (w_accept && !bus.imem_rsp_valid) begin
            w_out_d = r_outstanding + 1'b1;
        end else if (!w_accept && bus.imem_rsp_valid) begin
            w_out_d = r_outstanding - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (bus.redirect_valid) begin
            r_pc          <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_discard     <= w_flush_cnt;
            r_outstanding <= w_flush_cnt;
        end else begin
            r_outstanding <= w_out_d;
            if (w_accept)   r_pc      <= r_pc + XLEN'(4);
            if (w_rsp_drop) r_discard <= r_discard - 1'b1;
            if (w_rsp_keep) r_rsp_pc  <= r_rsp_pc + XLEN'(4);
            if (w_enq)      r_wr_ptr  <= r_wr_ptr + 1'b1;
            if (w_deq)      r_rd_ptr  <= r_rd_ptr + 1'b1;
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_enq && !bus.redirect_valid) begin
            r_mem_data[r_wr_ptr] <= w_enq_data;
            r_mem_pc[r_wr_ptr]   <= w_enq_pc;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.inst_valid     = r_count != '0;
    assign bus.inst_data      = r_mem_data[r_rd_ptr];
    assign bus.inst_pc        = r_mem_pc[r_rd_ptr];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench; a memory model answers requests in order, a monitor
// compares every delivered instruction and every queued spot check.
module tb_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    exp_t        exp_q[$];
    chk_t        chk_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    int cyc       = 0;
    int n_acc     = 0;
    int n_del     = 0;
    int acc_limit = 0;
    int lat       = 1;
    bit mem_stall = 1'b0;
    bit toggle    = 1'b0;
    int n_checks  = 0;
    int n_pass    = 0;
    logic [31:0] nxt = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: in-order responses lat cycles after accept; stall holds them back.
    always @(negedge clk) begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (!mem_stall && pend_due.size() != 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        bus.imem_req_ready = (n_acc < acc_limit) && (!toggle || cyc[0]);
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            pend_addr.push_back(bus.imem_addr);
            pend_due.push_back(cyc + lat);
            n_acc++;
        end
    end

    exp_t e;
    chk_t c;
    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.got === c.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h", c.name, c.got, c.exp);
        end
        if (rst_n && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            n_checks++;
            n_del++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_inst: got pc %h data %h expected no instruction",
                         bus.inst_pc, bus.inst_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.inst_pc === e.pc && bus.inst_data === e.data && bus.inst_fault === e.fault)
                    n_pass++;
                else
                    $display("FAIL inst_%0d: got pc %h data %h fault %b expected pc %h data %h fault %b",
                             n_del, bus.inst_pc, bus.inst_data, bus.inst_fault, e.pc, e.data, e.fault);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_q.push_back('{name: name, got: got, exp: exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: start + 32'(4 * i), data: mem_word(start + 32'(4 * i)), fault: 1'b0});
        end
        nxt = start + 32'(4 * n);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && pend_due.size() == 0) break;
            tick();
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
    endtask

    task automatic redirect(input logic [31:0] pc);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int first;
        int last;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_inst_fault", 32'(bus.inst_fault), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);

        // Streaming at one instruction per cycle.
        tick();
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        lat            = 1;
        base           = n_del;
        first          = -1;
        acc_limit      = n_acc + 8;
        expect_seq(RESET_PC, 8);
        for (int i = 0; i < 200 && n_del < base + 8; i++) begin
            tick();
            if (first < 0 && n_del > base) first = cyc;
        end
        last = cyc;
        chk("t1_span", 32'(last - first), 32'd7);
        wait_drain("t1_drain");

        // Backpressure: credit stops fetch at DEPTH.
        bus.inst_ready = 1'b0;
        base           = n_acc;
        acc_limit      = n_acc + 10;
        expect_seq(nxt, 10);
        repeat (12) tick();
        @(negedge clk);
        chk("t2_accepts", 32'(n_acc - base), 32'd4);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
        tick();
        bus.inst_ready = 1'b1;
        wait_drain("t2_drain");

        // Toggling ready with 3-cycle latency.
        toggle    = 1'b1;
        lat       = 3;
        acc_limit = n_acc + 8;
        expect_seq(nxt, 8);
        wait_drain("t3_drain");
        toggle = 1'b0;
        lat    = 1;

        // Redirect with three in flight, one response landing in the redirect cycle.
        mem_stall = 1'b1;
        base      = n_acc;
        acc_limit = n_acc + 3;
        repeat (6) tick();
        chk("t4_accepts", 32'(n_acc - base), 32'd3);
        redirect(32'h0100_0100);
        mem_stall = 1'b0;
        acc_limit = n_acc + 4;
        expect_seq(32'h0100_0100, 4);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flush", 32'(bus.inst_valid), 32'd0);
        wait_drain("t4_drain");

        // Redirect while the head handshakes: full queue must vanish.
        bus.inst_ready = 1'b0;
        acc_limit      = n_acc + 4;
        repeat (8) tick();
        chk("t5_full", 32'(bus.inst_valid), 32'd1);
        redirect(32'h0100_0300);
        bus.inst_ready = 1'b1;
        acc_limit      = n_acc + 3;
        expect_seq(32'h0100_0300, 3);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_flush", 32'(bus.inst_valid), 32'd0);
        wait_drain("t5_drain");

        // Misaligned redirect.
`ifdef FETCH_MISALIGN_CHECK_EN
        base = n_acc;
        redirect(32'h0100_0102);
        acc_limit = n_acc + 2;
        exp_q.push_back('{pc: 32'h0100_0102, data: 32'h0000_0013, fault: 1'b1});
        tick();
        bus.redirect_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("t6_halt_accepts", 32'(n_acc - base), 32'd0);
        chk("t6_halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
        wait_drain("t6_fault_drain");
        redirect(32'h0100_0200);
        expect_seq(32'h0100_0200, 2);
        tick();
        bus.redirect_valid = 1'b0;
        wait_drain("t6_resume_drain");
`else
        redirect(32'h0100_0102);
        acc_limit = n_acc + 3;
        expect_seq(32'h0100_0100, 3);
        tick();
        bus.redirect_valid = 1'b0;
        wait_drain("t6_align_drain");
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
